// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared types and constants for the load/store unit: FSM state
//               encoding, funct3 access-mode codes and the default bus
//               timeout.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_WAIT_R = 2'd2,
        ST_DONE   = 2'd3
    } lsu_state_t;

    // funct3 access modes
    localparam logic [2:0] MODE_B  = 3'b000;
    localparam logic [2:0] MODE_H  = 3'b001;
    localparam logic [2:0] MODE_W  = 3'b010;
    localparam logic [2:0] MODE_BU = 3'b100;
    localparam logic [2:0] MODE_HU = 3'b101;

    // Cycles allowed in REQ+WAIT_R before an access is aborted
    localparam int LSU_TIMEOUT = 16;

endpackage : lsu_pkg
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_lane_align
// Description : Combinational byte-lane logic for the load/store unit.
//               Store side: lane replication, byte strobes, misalign check
//               (driven from the live request). Load side: lane extraction
//               with sign/zero extension (driven from the latched access).
// Ports       : i_st_mode/i_st_offset/i_st_wdata -> o_st_bus_wdata,
//               o_st_strb, o_st_misalign
//               i_ld_mode/i_ld_offset/i_ld_word  -> o_ld_data
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_st_mode,
    input  logic [1:0]  i_st_offset,
    input  logic [31:0] i_st_wdata,
    output logic [31:0] o_st_bus_wdata,
    output logic [3:0]  o_st_strb,
    output logic        o_st_misalign,
    input  logic [2:0]  i_ld_mode,
    input  logic [1:0]  i_ld_offset,
    input  logic [31:0] i_ld_word,
    output logic [31:0] o_ld_data
);

    logic [7:0]  w_ld_byte;
    logic [15:0] w_ld_half;

    // Store steering; unknown funct3 codes fall back to word behaviour.
    always_comb begin
        o_st_bus_wdata = i_st_wdata;
        o_st_strb      = 4'b1111;
        o_st_misalign  = |i_st_offset;
        case (i_st_mode)
            MODE_B, MODE_BU: begin
                o_st_bus_wdata = {4{i_st_wdata[7:0]}};
                o_st_strb      = 4'b0001 << i_st_offset;
                o_st_misalign  = 1'b0;
            end
            MODE_H, MODE_HU: begin
                o_st_bus_wdata = {2{i_st_wdata[15:0]}};
                o_st_strb      = 4'b0011 << i_st_offset;
                o_st_misalign  = i_st_offset[0];
            end
            default: ;
        endcase
    end

    assign w_ld_byte = i_ld_word[{i_ld_offset, 3'b000} +: 8];
    assign w_ld_half = i_ld_offset[1] ? i_ld_word[31:16] : i_ld_word[15:0];

    always_comb begin
        o_ld_data = i_ld_word;
        case (i_ld_mode)
            MODE_B:  o_ld_data = {{24{w_ld_byte[7]}}, w_ld_byte};
            MODE_BU: o_ld_data = {24'h0, w_ld_byte};
            MODE_H:  o_ld_data = {{16{w_ld_half[15]}}, w_ld_half};
            MODE_HU: o_ld_data = {16'h0, w_ld_half};
            default: ;
        endcase
    end

endmodule : lsu_lane_align
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Multi-cycle load/store front end. Turns a MemRead/MemWrite
//               request into a valid/ready bus transaction, stalls the core
//               until completion, and returns extended load data with a
//               one-cycle done pulse. Misaligned requests and bus timeouts
//               complete through DONE with misalign/bus_error pulses.
// Ports       : core side  : req_read, req_write, addr, wdata, mode ->
//                            stall, rdata, done, misalign, bus_error
//               bus side   : bus_valid, bus_we, bus_addr, bus_wdata,
//                            bus_strb <- bus_ready, bus_rvalid, bus_rdata
//               clk, reset (asynchronous, active low)
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = LSU_TIMEOUT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_read,
    input  logic             req_write,
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [2:0]       mode,
    output logic             stall,
    output logic [WIDTH-1:0] rdata,
    output logic             done,
    output logic             misalign,
    output logic             bus_error,
    output logic             bus_valid,
    output logic             bus_we,
    output logic [WIDTH-1:0] bus_addr,
    output logic [WIDTH-1:0] bus_wdata,
    output logic [3:0]       bus_strb,
    input  logic             bus_ready,
    input  logic             bus_rvalid,
    input  logic [WIDTH-1:0] bus_rdata
);

    localparam int c_CNT_W = $clog2(TIMEOUT + 1);

    lsu_state_t         r_state, w_state_next;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2:0]         r_mode;
    logic [1:0]         r_offset;
    logic [WIDTH-1:0]   r_rdata, r_bus_addr, r_bus_wdata;
    logic [3:0]         r_bus_strb;
    logic               r_done, r_misalign, r_bus_error, r_bus_valid, r_bus_we;

    logic               w_req, w_misalign, w_cnt_expired;
    logic               w_latch, w_reject, w_handshake, w_capture, w_timeout;
    logic [WIDTH-1:0]   w_st_wdata, w_ld_data;
    logic [3:0]         w_st_strb;

    lsu_lane_align u_lane_align (
        .i_st_mode      (mode),
        .i_st_offset    (addr[1:0]),
        .i_st_wdata     (wdata),
        .o_st_bus_wdata (w_st_wdata),
        .o_st_strb      (w_st_strb),
        .o_st_misalign  (w_misalign),
        .i_ld_mode      (r_mode),
        .i_ld_offset    (r_offset),
        .i_ld_word      (bus_rdata),
        .o_ld_data      (w_ld_data)
    );

    assign w_req         = req_read | req_write;
    assign w_cnt_expired = (r_cnt == c_CNT_W'(TIMEOUT - 1));

    // Completion in REQ/WAIT_R takes priority over an expiring counter.
    always_comb begin
        w_state_next = r_state;
        w_latch      = 1'b0;
        w_reject     = 1'b0;
        w_handshake  = 1'b0;
        w_capture    = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    if (w_misalign) begin
                        w_reject     = 1'b1;
                        w_state_next = ST_DONE;
                    end else begin
                        w_latch      = 1'b1;
                        w_state_next = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (r_bus_valid && bus_ready) begin
                    w_handshake  = 1'b1;
                    w_state_next = r_bus_we ? ST_DONE : ST_WAIT_R;
                end else if (w_cnt_expired) begin
                    w_timeout    = 1'b1;
                    w_state_next = ST_DONE;
                end
            end
            ST_WAIT_R: begin
                if (bus_rvalid) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_DONE;
                end else if (w_cnt_expired) begin
                    w_timeout    = 1'b1;
                    w_state_next = ST_DONE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt       <= '0;
            r_mode      <= '0;
            r_offset    <= '0;
            r_rdata     <= '0;
            r_done      <= 1'b0;
            r_misalign  <= 1'b0;
            r_bus_error <= 1'b0;
            r_bus_valid <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_bus_strb  <= '0;
        end else begin
            // DONE is only ever entered from another state, so this is a
            // single-cycle pulse.
            r_done      <= (w_state_next == ST_DONE);
            r_misalign  <= w_reject;
            r_bus_error <= w_timeout;

            if (w_state_next == ST_DONE)
                r_rdata <= w_capture ? w_ld_data : '0;

            if (w_latch)
                r_cnt <= '0;
            else if (r_state == ST_REQ || r_state == ST_WAIT_R)
                r_cnt <= r_cnt + 1'b1;

            if (w_latch)
                r_bus_valid <= 1'b1;
            else if (w_handshake || w_timeout)
                r_bus_valid <= 1'b0;

            // Simultaneous read+write requests are treated as writes.
            if (w_latch) begin
                r_mode      <= mode;
                r_offset    <= addr[1:0];
                r_bus_we    <= req_write;
                r_bus_addr  <= {addr[WIDTH-1:2], 2'b00};
                r_bus_wdata <= w_st_wdata;
                r_bus_strb  <= w_st_strb;
            end
        end
    end

    assign stall     = (r_state == ST_REQ) || (r_state == ST_WAIT_R) ||
                       ((r_state == ST_IDLE) && w_req);
    assign rdata     = r_rdata;
    assign done      = r_done;
    assign misalign  = r_misalign;
    assign bus_error = r_bus_error;
    assign bus_valid = r_bus_valid;
    assign bus_we    = r_bus_we;
    assign bus_addr  = r_bus_addr;
    assign bus_wdata = r_bus_wdata;
    assign bus_strb  = r_bus_strb;

endmodule : load_store_unit
`default_nettype wire
